// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative RV32M multiply/divide unit.
//
// Sits between the register heap read ports (busA/busB) and its write port.
// A Start pulse in IDLE latches Op, Rd and both operands; the unit then runs
// 32 shift-add (multiply) or restoring-division (divide) iterations on operand
// magnitudes, applies the sign fix-up and presents a one-cycle write request.
//
// Ports:
//   Clk      clock, all state updates on the rising edge
//   Reset    synchronous active-high reset
//   Start    request, accepted only in IDLE
//   Op       RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   Rd       destination register index
//   SrcA     rs1 value, SrcB rs2 value
//   Busy     high while computing or presenting the result
//   Done     one-cycle pulse when the result is presented
//   WbRw     write-back register index (heap Rw)
//   WbRegWr  write enable (heap RegWr), suppressed for Rd == 0
//   WbBusW   write-back data (heap busW)
//
// Optional feature: define MULDIV_FAST_SPECIAL_EN to let divide-by-zero,
// signed overflow and multiply-by-zero skip the iteration phase entirely.
// Results are identical either way; only latency differs.

module mul_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Start,
   input  logic [2:0]      Op,
   input  logic [4:0]      Rd,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic            Busy,
   output logic            Done,
   output logic [4:0]      WbRw,
   output logic            WbRegWr,
   output logic [XLEN-1:0] WbBusW
);

   localparam int CntW = $clog2(XLEN);
   localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] AllOnes = '1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [CntW-1:0]   count;
   logic [2:0]        opReg;
   logic [4:0]        rdReg;
   logic [XLEN-1:0]   aReg;
   logic [XLEN-1:0]   bReg;
   logic [2*XLEN-1:0] work;
   logic [XLEN-1:0]   result;

   // Operand A is signed for everything except MULHU, DIVU and REMU.
   function automatic logic signedA(input logic [2:0] op);
      return !(op == 3'b011 || op == 3'b101 || op == 3'b111);
   endfunction

   // Operand B is signed only for MUL, MULH, DIV and REM.
   function automatic logic signedB(input logic [2:0] op);
      return (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b110);
   endfunction

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
   endfunction

   // Cases whose answer is known without iterating. Divide by zero is not
   // reachable by the sign fix-up, so it must always take this value.
   function automatic logic isSpecial(input logic [2:0] op, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
      if (op[2])
         return (b == '0) || (!op[0] && a == MinNeg && b == AllOnes);
      else
         return (a == '0) || (b == '0);
   endfunction

   function automatic logic [XLEN-1:0] specialValue(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
      if (!op[2])
         return '0;
      else if (b == '0)
         return op[1] ? a : AllOnes;
      else
         return op[1] ? '0 : MinNeg;
   endfunction

   logic              negA;
   logic              negB;
   logic [XLEN-1:0]   magA;
   logic [XLEN-1:0]   magB;
   logic [XLEN:0]     mulSum;
   logic [XLEN:0]     divShifted;
   logic [XLEN:0]     divDiff;
   logic [2*XLEN-1:0] workNext;
   logic [2*XLEN-1:0] prodFixed;
   logic [XLEN-1:0]   quotFixed;
   logic [XLEN-1:0]   remFixed;
   logic [XLEN-1:0]   finalValue;

   // One iteration step plus the sign fix-up of the step's outcome. The work
   // register holds {hi, lo}: for multiply the partial product with the
   // multiplier shifting out of lo, for divide the partial remainder in hi
   // and the dividend shifting into quotient bits in lo. The fix-up is taken
   // from workNext so the final iteration and the result land together.
   always_comb begin
      negA       = signedA(opReg) && aReg[XLEN-1];
      negB       = signedB(opReg) && bReg[XLEN-1];
      magA       = magnitude(aReg, signedA(opReg));
      magB       = magnitude(bReg, signedB(opReg));
      mulSum     = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, magA} : '0);
      divShifted = {work[2*XLEN-1:XLEN], work[XLEN-1]};
      divDiff    = divShifted - {1'b0, magB};
      workNext   = work;
      if (opReg[2]) begin
         if (!divDiff[XLEN])
            workNext = {divDiff[XLEN-1:0], work[XLEN-2:0], 1'b1};
         else
            workNext = {divShifted[XLEN-1:0], work[XLEN-2:0], 1'b0};
      end else begin
         workNext = {mulSum, work[XLEN-1:1]};
      end
      prodFixed = (negA ^ negB) ? (~workNext + 1'b1) : workNext;
      quotFixed = (negA ^ negB) ? (~workNext[XLEN-1:0] + 1'b1) : workNext[XLEN-1:0];
      remFixed  = negA ? (~workNext[2*XLEN-1:XLEN] + 1'b1) : workNext[2*XLEN-1:XLEN];
      if (isSpecial(opReg, aReg, bReg))
         finalValue = specialValue(opReg, aReg, bReg);
      else if (opReg[2])
         finalValue = opReg[1] ? remFixed : quotFixed;
      else if (opReg[1:0] == 2'b00)
         finalValue = prodFixed[XLEN-1:0];
      else
         finalValue = prodFixed[2*XLEN-1:XLEN];
   end

   // Control and datapath registers. A Start in IDLE preloads the work
   // register from the live inputs so the first iteration can run in the
   // very next cycle; Start is not looked at outside IDLE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         count  <= '0;
         opReg  <= '0;
         rdReg  <= '0;
         aReg   <= '0;
         bReg   <= '0;
         work   <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  opReg <= Op;
                  rdReg <= Rd;
                  aReg  <= SrcA;
                  bReg  <= SrcB;
                  count <= '0;
                  if (Op[2])
                     work <= {{XLEN{1'b0}}, magnitude(SrcA, signedA(Op))};
                  else
                     work <= {{XLEN{1'b0}}, magnitude(SrcB, signedB(Op))};
`ifdef MULDIV_FAST_SPECIAL_EN
                  if (isSpecial(Op, SrcA, SrcB)) begin
                     result <= specialValue(Op, SrcA, SrcB);
                     state  <= DONE;
                  end else begin
                     state  <= CALC;
                  end
`else
                  state <= CALC;
`endif
               end
            end
            CALC: begin
               work  <= workNext;
               count <= count + 1'b1;
               if (count == LastCnt) begin
                  result <= finalValue;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write request is visible only while presenting the result.
   always_comb begin
      Busy    = (state != IDLE);
      Done    = (state == DONE);
      WbRw    = Done ? rdReg : '0;
      WbRegWr = Done && (rdReg != '0);
      WbBusW  = Done ? result : '0;
   end

endmodule
